// File: rtl/life_pkg.sv
// Shared defaults, FSM state encoding and row-index arithmetic for the life row engine.
package life_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int ROWS_DEF  = 4;
    localparam int GEN_W_DEF = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WINDOW   = 2'd1;
    localparam logic [1:0] ST_COMPUTED = 2'd2;

    // Rows form a 4-entry torus, so 2-bit modular addition gives the wrap for free.
    function automatic logic [1:0] row_wrap(input logic [1:0] row, input logic [1:0] delta);
        return row + delta;
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational Game-of-Life rule: next state of the middle row from a 3-row window.
// Columns wrap around, so column 0 and column WIDTH-1 are neighbours.
module life_row_next #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] mid,
    input  logic [WIDTH-1:0] bot,
    output logic [WIDTH-1:0] next_row
);

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        localparam int L = (c + WIDTH - 1) % WIDTH;
        localparam int R = (c + 1) % WIDTH;
        logic [3:0] n;

        // The centre cell itself is excluded from its own neighbour count.
        assign n = 4'(top[L]) + 4'(top[c]) + 4'(top[R])
                 + 4'(mid[L])              + 4'(mid[R])
                 + 4'(bot[L]) + 4'(bot[c]) + 4'(bot[R]);

        assign next_row[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
    end

endmodule

// File: rtl/life_row_engine.sv
// Double-buffered toroidal life grid driven row by row by the sequencing controller.
// Window capture -> next row registered 1 cycle later -> commit to shadow bank; no backpressure.
module life_row_engine
    import life_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int GEN_W = GEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_array,
    input  logic             write_mem,
    input  logic [1:0]       pos,
    input  logic             load_en,
    input  logic [1:0]       load_row,
    input  logic [WIDTH-1:0] load_data,
    input  logic [1:0]       rd_row,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count,
    output logic             seq_err
);

    logic [WIDTH-1:0] grid [2][ROWS];
    logic             cur_bank;
    logic [1:0]       state;
    logic [1:0]       pos_q;
    logic [WIDTH-1:0] win_top;
    logic [WIDTH-1:0] win_mid;
    logic [WIDTH-1:0] win_bot;
    logic [WIDTH-1:0] next_row;
    logic [WIDTH-1:0] rule_row;

    logic commit_ok;
    logic load_ok;
    logic proto_err;

    life_row_next #(.WIDTH(WIDTH)) u_rule (
        .top      (win_top),
        .mid      (win_mid),
        .bot      (win_bot),
        .next_row (rule_row)
    );

    assign commit_ok = write_mem && !write_array && (state == ST_COMPUTED) && (pos == pos_q);
    assign load_ok   = load_en && !write_array && (state == ST_IDLE);

    // Any strobe that cannot be honoured as issued is flagged rather than silently absorbed.
    assign proto_err = (write_array && (state != ST_IDLE))
                     || (write_array && write_mem)
                     || (write_mem && !write_array && !commit_ok)
                     || (load_en && !load_ok);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    grid[b][r] <= '0;
                end
            end
            cur_bank  <= 1'b0;
            state     <= ST_IDLE;
            pos_q     <= 2'd0;
            win_top   <= '0;
            win_mid   <= '0;
            win_bot   <= '0;
            next_row  <= '0;
            rd_data   <= '0;
            gen_count <= '0;
            gen_done  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            gen_done <= 1'b0;
            seq_err  <= proto_err;
            rd_data  <= grid[cur_bank][rd_row];

            if (write_array) begin
                pos_q   <= pos;
                win_top <= grid[cur_bank][row_wrap(pos, 2'd3)];
                win_mid <= grid[cur_bank][pos];
                win_bot <= grid[cur_bank][row_wrap(pos, 2'd1)];
                state   <= ST_WINDOW;
            end else if (write_mem) begin
                state <= ST_IDLE;
                if (commit_ok) begin
                    grid[~cur_bank][pos_q] <= next_row;
                    // Last row committed: the shadow bank now holds a full generation.
                    if (pos_q == 2'd3) begin
                        cur_bank  <= ~cur_bank;
                        gen_count <= gen_count + GEN_W'(1);
                        gen_done  <= 1'b1;
                    end
                end
            end else if (state == ST_WINDOW) begin
                next_row <= rule_row;
                state    <= ST_COMPUTED;
            end

            if (load_ok) begin
                grid[cur_bank][load_row] <= load_data;
            end
        end
    end

endmodule
